// File: rtl/uart_memdump_ctrl.sv
// ---------------------------------------------------------------------------
// uart_memdump_ctrl
//
// Memory-dump controller. While idle it watches one memory address; when the
// sentinel word appears there (or when start is raised) it walks a window of
// DEPTH words starting at START_ADDR and streams every word to a byte-wide
// UART transmitter as one line of uppercase ASCII hex, optionally prefixed by
// the word address ("AAA: DDDDDDDD" + CR LF).
//
// Ports
//   CLK        clock
//   rst        asynchronous active-high reset
//   start      manual dump request (level, only looked at while idle)
//   mem_data   synchronous read data, valid MEM_LATENCY cycles after mem_addr
//   mem_addr   memory read address (WATCH_ADDR while idle)
//   tx_ready   UART_TX ready / idle
//   tx_send    one-cycle byte strobe to UART_TX
//   tx_data    byte for UART_TX, held until the next byte is emitted
//   busy       high from trigger acceptance until the end of the dump
//   done       one-cycle pulse after the final LF has been accepted
//   dbg_state  current FSM state (state_t encoding) for checkers / waves
//
// UART handshake: the controller pulses tx_send for one cycle only while
// tx_ready is high, then waits for tx_ready to fall (byte accepted) and rise
// again (byte shifted out) before the next byte. The transmitter must drop
// tx_ready within two cycles of tx_send.
// ---------------------------------------------------------------------------
module uart_memdump_ctrl #(
    parameter int          DATA_WIDTH   = 32,
    parameter int          ADDR_WIDTH   = 10,
    parameter int          START_ADDR   = 0,
    parameter int          DEPTH        = 1024,
    parameter int          WATCH_ADDR   = (1 << ADDR_WIDTH) - 1,
    parameter logic [31:0] TRIGGER_WORD = 32'hADE1B055,
    parameter int          MEM_LATENCY  = 1,
    parameter int          ADDR_PREFIX  = 1
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  tx_ready,
    output logic                  tx_send,
    output logic [7:0]            tx_data,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            dbg_state
);

    // -----------------------------------------------------------------------
    // Derived constants
    // -----------------------------------------------------------------------
    localparam int ADDR_DIGITS  = (ADDR_WIDTH + 3) / 4;
    localparam int ADDR_PAD_W   = ADDR_DIGITS * 4;
    localparam int DATA_DIGITS  = DATA_WIDTH / 4;
    localparam int PREFIX_CHARS = (ADDR_PREFIX != 0) ? ADDR_DIGITS + 2 : 0;
    localparam int LINE_CHARS   = PREFIX_CHARS + DATA_DIGITS + 2;

    localparam logic [DATA_WIDTH-1:0] TRIG      = DATA_WIDTH'(TRIGGER_WORD);
    localparam logic [ADDR_WIDTH-1:0] WATCH_A   = ADDR_WIDTH'(WATCH_ADDR);
    localparam logic [ADDR_WIDTH-1:0] START_A   = ADDR_WIDTH'(START_ADDR);
    localparam logic [ADDR_WIDTH-1:0] LAST_CNT  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [2:0]            LAT_LAST  = 3'(MEM_LATENCY - 1);
    localparam logic [2:0]            LAT_FULL  = 3'(MEM_LATENCY);
    localparam logic [5:0]            IDX_LAST  = 6'(LINE_CHARS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_LATCH   = 3'd2,
        S_EMIT    = 3'd3,
        S_WAIT_LO = 3'd4,
        S_WAIT_HI = 3'd5,
        S_NEXT    = 3'd6,
        S_FINISH  = 3'd7
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t                  state;
    logic                    armed;
    logic [ADDR_WIDTH-1:0]   word_cnt;
    logic [2:0]              lat_cnt;
    logic [5:0]              char_idx;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [ADDR_WIDTH-1:0]   addr_q;

    assign dbg_state = state;

    // -----------------------------------------------------------------------
    // Character generator: maps char_idx onto the line layout
    // [addr digits ':' ' '] data digits CR LF, most significant nibble first.
    // -----------------------------------------------------------------------
    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        if (nib < 4'd10) return 8'h30 + {4'h0, nib};
        else             return 8'h37 + {4'h0, nib};
    endfunction

    logic [ADDR_PAD_W-1:0] addr_pad;
    logic [ADDR_PAD_W-1:0] addr_shift;
    logic [DATA_WIDTH-1:0] data_shift;
    logic [7:0]            cur_char;
    int                    pos;

    // Zero-extending to whole digits makes unused top address bits read as 0.
    assign addr_pad = ADDR_PAD_W'(addr_q);

    always_comb begin
        pos        = int'(char_idx);
        addr_shift = '0;
        data_shift = '0;
        cur_char   = 8'h0A;
        if (pos < PREFIX_CHARS) begin
            if (pos < ADDR_DIGITS) begin
                addr_shift = addr_pad >> (4 * (ADDR_DIGITS - 1 - pos));
                cur_char   = hex_char(addr_shift[3:0]);
            end else if (pos == ADDR_DIGITS) begin
                cur_char = 8'h3A;
            end else begin
                cur_char = 8'h20;
            end
        end else if (pos < PREFIX_CHARS + DATA_DIGITS) begin
            data_shift = data_q >> (4 * (PREFIX_CHARS + DATA_DIGITS - 1 - pos));
            cur_char   = hex_char(data_shift[3:0]);
        end else if (pos == PREFIX_CHARS + DATA_DIGITS) begin
            cur_char = 8'h0D;
        end else begin
            cur_char = 8'h0A;
        end
    end

    // While idle, lat_cnt counts how long mem_addr has sat on WATCH_ADDR.
    // mem_data only reflects the watched word once MEM_LATENCY cycles have
    // passed; before that it still carries the last dumped word (or whatever
    // the memory held at reset), which must neither trigger nor rearm.
    logic watch_valid;
    assign watch_valid = (lat_cnt == LAT_FULL);

    // -----------------------------------------------------------------------
    // Controller FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            mem_addr <= WATCH_A;
            tx_send  <= 1'b0;
            tx_data  <= 8'h00;
            busy     <= 1'b0;
            done     <= 1'b0;
            armed    <= 1'b1;
            word_cnt <= '0;
            lat_cnt  <= '0;
            char_idx <= '0;
            data_q   <= '0;
            addr_q   <= '0;
        end else begin
            tx_send <= 1'b0;
            done    <= 1'b0;
            case (state)
                S_IDLE: begin
                    mem_addr <= WATCH_A;
                    if (!watch_valid) lat_cnt <= lat_cnt + 3'd1;
                    if (armed && (start || (watch_valid && mem_data == TRIG))) begin
                        armed    <= 1'b0;
                        busy     <= 1'b1;
                        mem_addr <= START_A;
                        word_cnt <= '0;
                        lat_cnt  <= '0;
                        state    <= S_FETCH;
                    end else if (!start && watch_valid && mem_data != TRIG) begin
                        armed <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (lat_cnt == LAT_LAST) state <= S_LATCH;
                    else                     lat_cnt <= lat_cnt + 3'd1;
                end
                S_LATCH: begin
                    data_q   <= mem_data;
                    addr_q   <= mem_addr;
                    char_idx <= '0;
                    state    <= S_EMIT;
                end
                S_EMIT: begin
                    tx_data <= cur_char;
                    tx_send <= 1'b1;
                    state   <= S_WAIT_LO;
                end
                S_WAIT_LO: begin
                    if (!tx_ready) state <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (tx_ready) begin
                        if (char_idx == IDX_LAST) begin
                            state <= S_NEXT;
                        end else begin
                            char_idx <= char_idx + 6'd1;
                            state    <= S_EMIT;
                        end
                    end
                end
                S_NEXT: begin
                    if (word_cnt == LAST_CNT) begin
                        state <= S_FINISH;
                    end else begin
                        word_cnt <= word_cnt + 1'b1;
                        mem_addr <= mem_addr + 1'b1;
                        lat_cnt  <= '0;
                        state    <= S_FETCH;
                    end
                end
                S_FINISH: begin
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    mem_addr <= WATCH_A;
                    lat_cnt  <= '0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_memdump_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_memdump_ctrl
//
// Two instances of the dump controller:
//   u_a : 32-bit words, 10-bit address, prefix on, window 3FE..001 (wraps),
//         sentinel-triggered, 1-cycle memory.
//   u_b : 16-bit words, 6-bit address, no prefix, window 62,63,0, 3-cycle
//         memory, start-triggered.
// Each has a memory model, a UART_TX model with programmable busy time and a
// monitor that pops expected bytes from its queue on every tx_send.
// ---------------------------------------------------------------------------
module tb_uart_memdump_ctrl;

    localparam logic [31:0] SENT_A = 32'hADE1B055;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;
    logic rst;

    int checks   = 0;
    int failures = 0;

    // ---------------- instance a signals ----------------
    logic        start_a;
    logic [31:0] mem_data_a;
    logic [9:0]  mem_addr_a;
    logic        tx_ready_a;
    logic        tx_send_a;
    logic [7:0]  tx_data_a;
    logic        busy_a;
    logic        done_a;
    logic [2:0]  dbg_a;
    logic [31:0] mem_a [1024];

    // ---------------- instance b signals ----------------
    logic        start_b;
    logic [15:0] mem_data_b;
    logic [5:0]  mem_addr_b;
    logic        tx_ready_b;
    logic        tx_send_b;
    logic [7:0]  tx_data_b;
    logic        busy_b;
    logic        done_b;
    logic [2:0]  dbg_b;
    logic [15:0] mem_b [64];
    logic [15:0] mem_b_p1, mem_b_p2;

    uart_memdump_ctrl #(
        .DATA_WIDTH(32), .ADDR_WIDTH(10), .START_ADDR(1022), .DEPTH(4),
        .MEM_LATENCY(1), .ADDR_PREFIX(1)
    ) u_a (
        .CLK(CLK), .rst(rst), .start(start_a), .mem_data(mem_data_a),
        .mem_addr(mem_addr_a), .tx_ready(tx_ready_a), .tx_send(tx_send_a),
        .tx_data(tx_data_a), .busy(busy_a), .done(done_a), .dbg_state(dbg_a)
    );

    uart_memdump_ctrl #(
        .DATA_WIDTH(16), .ADDR_WIDTH(6), .START_ADDR(62), .DEPTH(3),
        .MEM_LATENCY(3), .ADDR_PREFIX(0)
    ) u_b (
        .CLK(CLK), .rst(rst), .start(start_b), .mem_data(mem_data_b),
        .mem_addr(mem_addr_b), .tx_ready(tx_ready_b), .tx_send(tx_send_b),
        .tx_data(tx_data_b), .busy(busy_b), .done(done_b), .dbg_state(dbg_b)
    );

    // ---------------- memory models ----------------
    always @(posedge CLK) mem_data_a <= mem_a[mem_addr_a];

    always @(posedge CLK) begin
        mem_b_p1   <= mem_b[mem_addr_b];
        mem_b_p2   <= mem_b_p1;
        mem_data_b <= mem_b_p2;
    end

    // ---------------- UART_TX models ----------------
    int stall_a = 0;
    int hold_a  = 0;
    int hold_b  = 0;

    always @(posedge CLK or posedge rst) begin
        if (rst) begin
            tx_ready_a <= 1'b1;
            hold_a     <= 0;
        end else if (tx_send_a) begin
            tx_ready_a <= 1'b0;
            hold_a     <= stall_a;
        end else if (!tx_ready_a) begin
            if (hold_a == 0) tx_ready_a <= 1'b1;
            else             hold_a <= hold_a - 1;
        end
    end

    always @(posedge CLK or posedge rst) begin
        if (rst) begin
            tx_ready_b <= 1'b1;
            hold_b     <= 0;
        end else if (tx_send_b) begin
            tx_ready_b <= 1'b0;
            hold_b     <= 1;
        end else if (!tx_ready_b) begin
            if (hold_b == 0) tx_ready_b <= 1'b1;
            else             hold_b <= hold_b - 1;
        end
    end

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q_a [$];
    logic [7:0] exp_q_b [$];
    logic [5:0] addr_seen_b [$];
    int         done_cnt [2] = '{0, 0};
    int         bytes_a = 0, bytes_b = 0;
    int         proto_err_a = 0, proto_err_b = 0;
    int         hold_err_a = 0;
    logic [7:0] last_a = 8'h00;
    logic [7:0] exp_byte_a, exp_byte_b;

    always @(negedge CLK) begin
        if (rst) begin
            last_a = 8'h00;
        end else begin
            if (done_a) done_cnt[0]++;
            if (tx_send_a) begin
                bytes_a++;
                if (!tx_ready_a) proto_err_a++;
                checks++;
                if (exp_q_a.size() == 0) begin
                    failures++;
                    $display("FAIL byte_a: got %02h, no byte expected", tx_data_a);
                end else begin
                    exp_byte_a = exp_q_a.pop_front();
                    if (tx_data_a !== exp_byte_a) begin
                        failures++;
                        $display("FAIL byte_a #%0d: got %02h expected %02h", bytes_a, tx_data_a, exp_byte_a);
                    end
                end
                last_a = tx_data_a;
            end else if (busy_a && tx_data_a !== last_a) begin
                hold_err_a++;
            end
        end
    end

    always @(negedge CLK) begin
        if (!rst) begin
            if (done_b) done_cnt[1]++;
            if (busy_b && (addr_seen_b.size() == 0 || mem_addr_b != addr_seen_b[$]))
                addr_seen_b.push_back(mem_addr_b);
            if (tx_send_b) begin
                bytes_b++;
                if (!tx_ready_b) proto_err_b++;
                checks++;
                if (exp_q_b.size() == 0) begin
                    failures++;
                    $display("FAIL byte_b: got %02h, no byte expected", tx_data_b);
                end else begin
                    exp_byte_b = exp_q_b.pop_front();
                    if (tx_data_b !== exp_byte_b) begin
                        failures++;
                        $display("FAIL byte_b #%0d: got %02h expected %02h", bytes_b, tx_data_b, exp_byte_b);
                    end
                end
            end
        end
    end

    // ---------------- driver / helper tasks ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_str_a(input string s, input logic add_crlf);
        for (int i = 0; i < s.len(); i++) exp_q_a.push_back(s[i]);
        if (add_crlf) begin
            exp_q_a.push_back(8'h0D);
            exp_q_a.push_back(8'h0A);
        end
    endtask

    task automatic push_line_b(input string s);
        for (int i = 0; i < s.len(); i++) exp_q_b.push_back(s[i]);
        exp_q_b.push_back(8'h0D);
        exp_q_b.push_back(8'h0A);
    endtask

    task automatic push_window_a;
        push_str_a("3FE: 000003FE", 1'b1);
        push_str_a("3FF: ADE1B055", 1'b1);
        push_str_a("000: 00000000", 1'b1);
        push_str_a("001: 00000001", 1'b1);
    endtask

    task automatic wait_done(input int which, input int budget);
        int base;
        int n;
        base = done_cnt[which];
        n    = 0;
        while (done_cnt[which] == base && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check($sformatf("done_seen_%0d", which), 64'(done_cnt[which] - base), 64'd1);
    endtask

    // ---------------- stimulus ----------------
    logic [5:0] exp_addr_b [3] = '{6'd62, 6'd63, 6'd0};
    int         lat_n;
    int         guard;

    initial begin
        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        for (int i = 0; i < 1024; i++) mem_a[i] = 32'(i);
        for (int i = 0; i < 64; i++) mem_b[i] = 16'h0000;
        mem_b[62] = 16'hBEEF;
        mem_b[63] = 16'h0A5C;
        mem_b[0]  = 16'hFFFF;

        // reset state
        repeat (3) @(negedge CLK);
        check("rst_mem_addr_a", 64'(mem_addr_a), 64'h3FF);
        check("rst_mem_addr_b", 64'(mem_addr_b), 64'h3F);
        check("rst_tx_send_a",  64'(tx_send_a),  64'd0);
        check("rst_tx_data_a",  64'(tx_data_a),  64'h00);
        check("rst_busy_a",     64'(busy_a),     64'd0);
        check("rst_done_a",     64'(done_a),     64'd0);
        rst = 1'b0;
        repeat (6) @(negedge CLK);
        check("idle_no_trigger_a", 64'(busy_a), 64'd0);

        // ---- u_b: start pulse, 3-cycle memory, wrapping no-prefix window ----
        push_line_b("BEEF");
        push_line_b("0A5C");
        push_line_b("FFFF");
        start_b = 1'b1;
        @(posedge CLK);
        #1;
        start_b = 1'b0;
        check("busy_b_after_trigger", 64'(busy_b), 64'd1);
        lat_n = 0;
        while (!tx_send_b && lat_n < 20) begin
            @(posedge CLK);
            #1;
            lat_n++;
        end
        check("first_send_latency_b", 64'(lat_n), 64'd5);
        wait_done(1, 2000);
        repeat (10) @(negedge CLK);
        check("done_pulses_b",   64'(done_cnt[1]),       64'd1);
        check("busy_b_after",    64'(busy_b),            64'd0);
        check("exp_q_b_drained", 64'(exp_q_b.size()),    64'd0);
        check("addr_seq_len_b",  64'(addr_seen_b.size()), 64'd3);
        for (int i = 0; i < 3 && i < addr_seen_b.size(); i++)
            check($sformatf("addr_seq_b_%0d", i), 64'(addr_seen_b[i]), 64'(exp_addr_b[i]));

        // ---- u_a: sentinel trigger, window wraps through 000 ----
        push_window_a();
        mem_a[1023] = SENT_A;
        wait_done(0, 5000);
        repeat (200) @(negedge CLK);    // sentinel stays in memory
        check("done_pulses_a1", 64'(done_cnt[0]),    64'd1);
        check("busy_a_after1",  64'(busy_a),         64'd0);
        check("bytes_a1",       64'(bytes_a),        64'd60);
        check("mem_addr_a_idle", 64'(mem_addr_a),    64'h3FF);
        check("exp_q_a_drained1", 64'(exp_q_a.size()), 64'd0);

        // ---- u_a: clear + rewrite sentinel, slow transmitter ----
        mem_a[1023] = 32'h0000_03FF;
        repeat (5) @(negedge CLK);
        stall_a = 50;
        push_window_a();
        mem_a[1023] = SENT_A;
        wait_done(0, 20000);
        stall_a = 0;
        repeat (100) @(negedge CLK);
        check("done_pulses_a2",   64'(done_cnt[0]),    64'd2);
        check("bytes_a2",         64'(bytes_a),        64'd120);
        check("exp_q_a_drained2", 64'(exp_q_a.size()), 64'd0);

        // ---- u_a: reset in the middle of a line ----
        mem_a[1023] = 32'h0000_03FF;
        repeat (5) @(negedge CLK);
        push_str_a("3FE:", 1'b0);
        start_a = 1'b1;
        guard = 0;
        while (!busy_a && guard < 20) begin
            @(negedge CLK);
            guard++;
        end
        start_a = 1'b0;
        check("busy_a_on_start", 64'(busy_a), 64'd1);
        guard = 0;
        while (bytes_a < 124 && guard < 500) begin
            @(negedge CLK);
            guard++;
        end
        check("bytes_before_reset", 64'(bytes_a), 64'd124);
        rst = 1'b1;
        #1;
        check("midrst_tx_send_a",  64'(tx_send_a),  64'd0);
        check("midrst_tx_data_a",  64'(tx_data_a),  64'h00);
        check("midrst_busy_a",     64'(busy_a),     64'd0);
        check("midrst_done_a",     64'(done_a),     64'd0);
        check("midrst_mem_addr_a", 64'(mem_addr_a), 64'h3FF);
        check("midrst_state_a",    64'(dbg_a),      64'd0);
        @(negedge CLK);
        rst = 1'b0;
        repeat (100) @(negedge CLK);
        check("bytes_after_reset", 64'(bytes_a),     64'd124);
        check("busy_a_after_rst",  64'(busy_a),      64'd0);
        check("done_after_rst",    64'(done_cnt[0]), 64'd2);

        // ---- protocol summaries ----
        check("tx_data_hold_a",     64'(hold_err_a),  64'd0);
        check("send_while_busy_a",  64'(proto_err_a), 64'd0);
        check("send_while_busy_b",  64'(proto_err_b), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_memdump_ctrl.md
Name: uart_memdump_ctrl

Overview:
- Parametrised memory-dump controller: on trigger, walks a memory window and streams each word over UART as uppercase ASCII hex lines terminated with CR LF.
- Optional per-line address prefix and configurable memory read latency.
- Sits between a synchronous-read data memory port and the team's UART_TX byte transmitter (SEND/DATA/READY contract).
- Successor to the fixed 32-bit/1K-word dumper: adds width, depth, window, latency and prefix generality, an explicit start input, rearm protection and a robust TX handshake.

Parameters:
- DATA_WIDTH, 32, memory word width; multiple of 4, range 4..64.
- ADDR_WIDTH, 10, memory address width.
- START_ADDR, 0, first word address dumped.
- DEPTH, 1024, number of words dumped; 1..2^ADDR_WIDTH.
- WATCH_ADDR, 2^ADDR_WIDTH-1, address monitored while idle.
- TRIGGER_WORD, 32'hADE1B055 (truncated/zero-extended to DATA_WIDTH), sentinel value that starts a dump.
- MEM_LATENCY, 1, cycles from mem_addr change to valid mem_data; 1..4.
- ADDR_PREFIX, 1, when 1 each line starts with the address in hex, then ':' and ' '.

Ports:
- CLK  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  manual dump request; level, sampled in IDLE.
- mem_data  in  DATA_WIDTH  read data from memory.
- mem_addr  out  ADDR_WIDTH  memory read address.
- tx_ready  in  1  UART_TX idle/ready.
- tx_send  out  1  one-cycle byte strobe to UART_TX.
- tx_data  out  8  byte to transmit.
- busy  out  1  high from trigger acceptance until dump end.
- done  out  1  one-cycle pulse after the final LF is accepted.

Behaviour:
- Reset values (async, immediate): state IDLE, mem_addr=WATCH_ADDR, tx_send=0, tx_data=8'h00, busy=0, done=0, armed=1. All outputs registered.
- Reset mid-dump: abort at once, return to the reset values, no further bytes.
- Trigger condition: armed && (start || mem_data==TRIGGER_WORD), evaluated in IDLE only.
- Rearm: armed clears on trigger and sets only when an IDLE cycle sees !start && mem_data!=TRIGGER_WORD. A persistent sentinel therefore produces exactly one dump.
- States: IDLE, FETCH, LATCH, EMIT, WAIT_LO, WAIT_HI, NEXT, FINISH.
- IDLE: mem_addr held at WATCH_ADDR. On trigger: busy<=1, mem_addr<=START_ADDR, word counter<=0, go to FETCH.
- FETCH: wait MEM_LATENCY cycles, then go to LATCH.
- LATCH: capture mem_data and mem_addr into shadow registers, clear char index, go to EMIT.
- Line format, MSB nibble first:
  - if ADDR_PREFIX: ceil(ADDR_WIDTH/4) address digits, then 0x3A, then 0x20;
  - then DATA_WIDTH/4 data digits;
  - then 0x0D, then 0x0A.
- Digit encoding: 0..9 -> 0x30..0x39, A..F -> 0x41..0x46. Unused top address bits read as 0.
- EMIT: tx_data<=current char, tx_send<=1 for exactly one cycle, go to WAIT_LO. tx_data holds until the next EMIT.
- WAIT_LO: wait for tx_ready==0 (byte accepted), then go to WAIT_HI. UART_TX must drop READY within 2 cycles of SEND.
- WAIT_HI: wait for tx_ready==1.
  - If the character was not LF: char index+1, go to EMIT.
  - If it was LF: go to NEXT.
- NEXT:
  - If word counter==DEPTH-1: go to FINISH.
  - Otherwise: counter+1, mem_addr<=mem_addr+1 (wraps modulo 2^ADDR_WIDTH), go to FETCH.
- FINISH: done<=1 for one cycle, busy<=0, mem_addr<=WATCH_ADDR, go to IDLE.
- Latency: trigger sampled at edge k; first tx_send is high in cycle k+MEM_LATENCY+2.
- start and mem_data changes during a dump are ignored, except the captured word.
- DEPTH=1 produces one line, then done. A window that crosses the top address wraps to 0.

Test Plan:
- Defaults, MEM_LATENCY=1, mem[0..1023]=i, mem[1023]=ADE1B055 -> 1024 lines; first line "000: 00000000\r\n"; last line "3FF: ADE1B055\r\n"; done pulses once; busy low after.
- Sentinel held after done -> no second dump. Clear mem[1023], then rewrite the sentinel -> exactly one more dump.
- DATA_WIDTH=16, ADDR_WIDTH=6, ADDR_PREFIX=0, START_ADDR=62, DEPTH=3, start pulse, mem[62]=BEEF, mem[63]=0A5C, mem[0]=FFFF -> bytes "BEEF\r\n0A5C\r\nFFFF\r\n"; mem_addr sequence 62, 63, 0.
- MEM_LATENCY=3, mem[5]=12345678, START_ADDR=5, DEPTH=1 -> first tx_send 5 cycles after trigger; line "005: 12345678\r\n".
- tx_ready held low for 50 cycles after each send -> no extra tx_send; bytes in order; tx_data stable while waiting.
- rst asserted mid-line (after the 4th byte), released, no trigger -> outputs immediately at reset values; no further tx_send.
